cam_core: RTL and testbench

- Parameterised content-addressable memory of 2^CAM_AW entries, each CAM_DW bits, with one valid bit per entry.
- Entries are written by address.
- A search compares a masked key against the low CAM_MW bits of every valid entry. It returns the lowest matching address and that entry's data.
- A hit result is held until the consumer acknowledges it.
- Sits between a table-update agent (write port) and a lookup client (search/result port).

---
 rtl/cam_core.sv | 168 ++++++++++++++++
 tb/tb_cam_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_core.sv
// cam_core: content-addressable memory of 2^CAM_AW entries of CAM_DW bits,
// one valid bit per entry. Entries are written by address. A search compares
// a masked key against the low CAM_MW bits of every valid entry and returns
// the lowest matching address and that entry's data. A hit is held until the
// consumer acknowledges it.
//
// Optional feature: define CAM_MULTI_HIT_EN to add the multi_hit output
// (more than one valid entry matched the captured search).
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous reset, ACTIVE-HIGH (name kept for consistency)
//   data_in      write data
//   addr_in      write address
//   input_valid  write strobe: mem[addr_in] <= data_in, entry marked valid
//   mask_in      search key
//   mask_strb    per-bit compare enable (0 = wildcard)
//   mask_en      search request (level)
//   data_valid   consumer acknowledge of a held hit
//   data_out     data of matched entry
//   addr_out     address of matched entry
//   hit          a match is held on data_out/addr_out
//   data_ready   a search result is valid this cycle
//   multi_hit    (CAM_MULTI_HIT_EN only) multiple entries matched
module cam_core #(
    parameter int CAM_DW = 32,
    parameter int CAM_MW = 3,
    parameter int CAM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CAM_DW-1:0] data_in,
    input  logic [CAM_AW-1:0] addr_in,
    input  logic              input_valid,
    input  logic [CAM_MW-1:0] mask_in,
    input  logic [CAM_MW-1:0] mask_strb,
    input  logic              mask_en,
    input  logic              data_valid,
    output logic [CAM_DW-1:0] data_out,
    output logic [CAM_AW-1:0] addr_out,
    output logic              hit,
    output logic              data_ready
`ifdef CAM_MULTI_HIT_EN
    ,
    output logic              multi_hit
`endif
);

    localparam int DEPTH = 1 << CAM_AW;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t            state;
    logic [CAM_DW-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;

    logic [DEPTH-1:0]  match_p0;
    logic              found_p0;
    logic [CAM_AW-1:0] win_addr_p0;
    logic [CAM_DW-1:0] win_data_p0;
`ifdef CAM_MULTI_HIT_EN
    logic              multi_p0;
`endif

    // Stage p0: parallel compare of every entry against the masked key,
    // using the table contents as they stood before this edge's write.
    always_comb begin
        match_p0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_p0[i] = valid[i] & ~|((mem[i][CAM_MW-1:0] ^ mask_in) & mask_strb);
        end
    end

    // Priority encoder: first match scanning upward is the lowest address.
    always_comb begin
        found_p0    = 1'b0;
        win_addr_p0 = '0;
`ifdef CAM_MULTI_HIT_EN
        multi_p0    = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (match_p0[i]) begin
                if (!found_p0) begin
                    found_p0    = 1'b1;
                    win_addr_p0 = CAM_AW'(i);
                end
`ifdef CAM_MULTI_HIT_EN
                else begin
                    multi_p0 = 1'b1;
                end
`endif
            end
        end
    end

    assign win_data_p0 = mem[win_addr_p0];

    // Entry data is not reset; a write coinciding with reset is dropped
    // (rst_n is active-high, so !rst_n means "not in reset").
    always_ff @(posedge clk) begin
        if (!rst_n && input_valid) begin
            mem[addr_in] <= data_in;
        end
    end

    // Stage p1: result register and IDLE/HELD control.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid      <= '0;
            state      <= IDLE;
            hit        <= 1'b0;
            data_ready <= 1'b0;
            data_out   <= '0;
            addr_out   <= '0;
`ifdef CAM_MULTI_HIT_EN
            multi_hit  <= 1'b0;
`endif
        end else begin
            if (input_valid) begin
                valid[addr_in] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // Acks arriving while idle are ignored.
                    if (mask_en && found_p0) begin
                        hit        <= 1'b1;
                        data_ready <= 1'b1;
                        data_out   <= win_data_p0;
                        addr_out   <= win_addr_p0;
`ifdef CAM_MULTI_HIT_EN
                        multi_hit  <= multi_p0;
`endif
                        state      <= HELD;
                    end else begin
                        // A miss reports data_ready and re-searches next cycle.
                        hit        <= 1'b0;
                        data_ready <= mask_en;
                        data_out   <= '0;
                        addr_out   <= '0;
`ifdef CAM_MULTI_HIT_EN
                        multi_hit  <= 1'b0;
`endif
                    end
                end
                HELD: begin
                    // Outputs stay frozen (even if the matched entry is
                    // rewritten) until the consumer acknowledges.
                    if (data_valid) begin
                        hit        <= 1'b0;
                        data_ready <= 1'b0;
                        data_out   <= '0;
                        addr_out   <= '0;
`ifdef CAM_MULTI_HIT_EN
                        multi_hit  <= 1'b0;
`endif
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_core.sv
module tb_cam_core;

    localparam int DW    = 32;
    localparam int MW    = 3;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr_in;
    logic          input_valid;
    logic [MW-1:0] mask_in;
    logic [MW-1:0] mask_strb;
    logic          mask_en;
    logic          data_valid;
    logic [DW-1:0] data_out;
    logic [AW-1:0] addr_out;
    logic          hit;
    logic          data_ready;
`ifdef CAM_MULTI_HIT_EN
    logic          multi_hit;
`endif

    cam_core #(.CAM_DW(DW), .CAM_MW(MW), .CAM_AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .addr_in     (addr_in),
        .input_valid (input_valid),
        .mask_in     (mask_in),
        .mask_strb   (mask_strb),
        .mask_en     (mask_en),
        .data_valid  (data_valid),
        .data_out    (data_out),
        .addr_out    (addr_out),
        .hit         (hit),
        .data_ready  (data_ready)
`ifdef CAM_MULTI_HIT_EN
        ,
        .multi_hit   (multi_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: table contents plus the currently held result.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_val [DEPTH];
    bit            m_held;
    bit            e_hit, e_dr, e_multi;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic model_step(input bit rst, input bit wv, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input bit men,
                              input logic [MW-1:0] key, input logic [MW-1:0] strb,
                              input bit ack);
        int cnt;
        int first;
        if (rst) begin
            foreach (m_val[i]) m_val[i] = 1'b0;
            m_held = 0; e_hit = 0; e_dr = 0; e_multi = 0; e_addr = '0; e_data = '0;
            return;
        end
        if (m_held) begin
            if (ack) begin
                m_held = 0; e_hit = 0; e_dr = 0; e_multi = 0; e_addr = '0; e_data = '0;
            end
        end else if (men) begin
            cnt = 0; first = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_val[i] && (((m_mem[i][MW-1:0] ^ key) & strb) == '0)) begin
                    if (cnt == 0) first = i;
                    cnt++;
                end
            end
            e_dr = 1;
            if (cnt > 0) begin
                m_held = 1; e_hit = 1; e_multi = (cnt > 1);
                e_addr = AW'(first); e_data = m_mem[first];
            end else begin
                e_hit = 0; e_multi = 0; e_addr = '0; e_data = '0;
            end
        end else begin
            e_hit = 0; e_dr = 0; e_multi = 0;
        end
        if (wv) begin
            m_mem[wa] = wd;
            m_val[wa] = 1'b1;
        end
    endtask

    // Apply the currently driven inputs for one clock and check against the model.
    task automatic cycle();
        bit            s_rst, s_wv, s_men, s_ack;
        logic [AW-1:0] s_wa;
        logic [DW-1:0] s_wd;
        logic [MW-1:0] s_key, s_strb;
        s_rst = rst_n; s_wv = input_valid; s_wa = addr_in; s_wd = data_in;
        s_men = mask_en; s_key = mask_in; s_strb = mask_strb; s_ack = data_valid;
        @(posedge clk);
        #1;
        model_step(s_rst, s_wv, s_wa, s_wd, s_men, s_key, s_strb, s_ack);
        chk("model_hit", 32'(hit), 32'(e_hit));
        chk("model_data_ready", 32'(data_ready), 32'(e_dr));
        if (e_hit || e_dr) begin
            chk("model_addr_out", 32'(addr_out), 32'(e_addr));
            chk("model_data_out", data_out, e_data);
        end
`ifdef CAM_MULTI_HIT_EN
        chk("model_multi_hit", 32'(multi_hit), 32'(e_multi));
`endif
    endtask

    typedef struct {
        bit            rst;
        bit            wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            men;
        logic [MW-1:0] key;
        logic [MW-1:0] strb;
        bit            ack;
        bit            eh;
        bit            edr;
        bit            cda;   // check addr/data as well
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } vec_t;

    function automatic vec_t v(bit rst, bit wv, logic [AW-1:0] wa, logic [DW-1:0] wd,
                               bit men, logic [MW-1:0] key, logic [MW-1:0] strb, bit ack,
                               bit eh, bit edr, bit cda, logic [AW-1:0] ea, logic [DW-1:0] ed);
        vec_t r;
        r.rst = rst; r.wv = wv; r.wa = wa; r.wd = wd; r.men = men; r.key = key;
        r.strb = strb; r.ack = ack; r.eh = eh; r.edr = edr; r.cda = cda; r.ea = ea; r.ed = ed;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        //               rst wv wa     wd            men key     strb    ack  eh edr cda ea     ed
        tbl.push_back(v(1, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 0,  0, 0, 1, 8'h00, 32'h0));
        tbl.push_back(v(1, 1, 8'h20, 32'h7,        1, 3'b111, 3'b111, 1,  0, 0, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b101, 3'b000, 0,  0, 1, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b101, 3'b000, 1,  0, 1, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 1, 8'h01, 32'hFFFFFFFF, 1, 3'b111, 3'b111, 0,  0, 1, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b111, 3'b111, 0,  1, 1, 1, 8'h01, 32'hFFFFFFFF));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b111, 3'b111, 0,  1, 1, 1, 8'h01, 32'hFFFFFFFF));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b111, 3'b111, 1,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b111, 3'b111, 0,  1, 1, 1, 8'h01, 32'hFFFFFFFF));
        tbl.push_back(v(0, 1, 8'h01, 32'h0,        0, 3'b111, 3'b111, 0,  1, 1, 1, 8'h01, 32'hFFFFFFFF));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        0, 3'b111, 3'b111, 0,  1, 1, 1, 8'h01, 32'hFFFFFFFF));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 1,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 0,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 1, 8'h10, 32'h5,        0, 3'b000, 3'b000, 0,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 1, 8'h03, 32'h5,        0, 3'b000, 3'b000, 0,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b101, 3'b111, 0,  1, 1, 1, 8'h03, 32'h5));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 1,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 1, 8'h07, 32'h2,        0, 3'b000, 3'b000, 0,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b011, 3'b110, 0,  1, 1, 1, 8'h07, 32'h2));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 1,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b011, 3'b111, 0,  0, 1, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b011, 3'b000, 0,  1, 1, 1, 8'h01, 32'h0));
        tbl.push_back(v(1, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 0,  0, 0, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b000, 3'b000, 0,  0, 1, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 1, 8'h20, 32'h7,        1, 3'b111, 3'b111, 0,  0, 1, 1, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        1, 3'b111, 3'b111, 0,  1, 1, 1, 8'h20, 32'h7));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 1,  0, 0, 0, 8'h00, 32'h0));
        tbl.push_back(v(0, 0, 8'h00, 32'h0,        0, 3'b000, 3'b000, 0,  0, 0, 0, 8'h00, 32'h0));

        rst_n = 1'b1; input_valid = 1'b0; addr_in = '0; data_in = '0;
        mask_en = 1'b0; mask_in = '0; mask_strb = '0; data_valid = 1'b0;
        foreach (m_val[i]) begin
            m_val[i] = 1'b0;
            m_mem[i] = '0;
        end
        m_held = 0; e_hit = 0; e_dr = 0; e_multi = 0; e_addr = '0; e_data = '0;
        @(posedge clk);
        #1;

        // Directed sequence from the table, checked against literal expectations.
        for (int k = 0; k < tbl.size(); k++) begin
            rst_n = tbl[k].rst; input_valid = tbl[k].wv; addr_in = tbl[k].wa;
            data_in = tbl[k].wd; mask_en = tbl[k].men; mask_in = tbl[k].key;
            mask_strb = tbl[k].strb; data_valid = tbl[k].ack;
            cycle();
            chk($sformatf("vec%0d_hit", k), 32'(hit), 32'(tbl[k].eh));
            chk($sformatf("vec%0d_data_ready", k), 32'(data_ready), 32'(tbl[k].edr));
            if (tbl[k].cda) begin
                chk($sformatf("vec%0d_addr_out", k), 32'(addr_out), 32'(tbl[k].ea));
                chk($sformatf("vec%0d_data_out", k), data_out, tbl[k].ed);
            end
`ifdef CAM_MULTI_HIT_EN
            if (k == 15) chk("vec15_multi_hit", 32'(multi_hit), 32'd1);
            if (k == 18) chk("vec18_multi_hit", 32'(multi_hit), 32'd0);
`endif
        end

        // Randomised traffic against the model; writes biased to a small
        // address window so searches find multiple candidates.
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 299) == 0);
            input_valid = ($urandom_range(0, 2) == 0);
            addr_in     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            data_in     = $urandom;
            mask_en     = ($urandom_range(0, 2) != 0);
            mask_in     = MW'($urandom);
            mask_strb   = MW'($urandom);
            data_valid  = ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
